// File: rtl/mito_acc_core_if.sv
// Handshake bundle between the input buffers, the mito_acc_core and the OFM buffer.
// The master side feeds config and beats and takes results; the slave side is the core.
interface mito_acc_core_if #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 9,
  parameter int N_CH    = 4,
  parameter int BEATS_W = 8,
  parameter int SHIFT_W = 4
);
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [1:0]                   cfg_mode;
  logic [BEATS_W-1:0]           cfg_beats;
  logic [SHIFT_W-1:0]           cfg_shift;
  logic                         cfg_relu;
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*DATA_W-1:0]      ifm_data;
  logic [N_CH*LANES*DATA_W-1:0] wgt_data;
  logic [N_CH*DATA_W-1:0]       bias_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [N_CH*DATA_W-1:0]       ofm_data;
  logic                         busy;
  logic                         err_mode;

  modport master (
    output cfg_valid, cfg_mode, cfg_beats, cfg_shift, cfg_relu,
    output in_valid, ifm_data, wgt_data, bias_data, out_ready,
    input  cfg_ready, in_ready, out_valid, ofm_data, busy, err_mode
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_beats, cfg_shift, cfg_relu,
    input  in_valid, ifm_data, wgt_data, bias_data, out_ready,
    output cfg_ready, in_ready, out_valid, ofm_data, busy, err_mode
  );
endinterface

// File: rtl/mito_acc_core.sv
// Tile accelerator core: per-channel MAC or max-pool over a configured number of beats,
// then bias, requantising shift, optional ReLU and saturation into one N_CH-wide OFM word.
module mito_acc_core #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int LANES   = 9,
  parameter int N_CH    = 4,
  parameter int BEATS_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  mito_acc_core_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [1:0] M_ILL   = 2'b00;
  localparam logic [1:0] M_CONV  = 2'b01;
  localparam logic [1:0] M_FULLY = 2'b10;
  localparam logic [1:0] M_POOL  = 2'b11;

  localparam logic [BEATS_W-1:0] BEAT_ZERO = {BEATS_W{1'b0}};
  localparam logic [BEATS_W-1:0] BEAT_ONE  = {{(BEATS_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  function automatic logic signed [ACC_W-1:0] sext_d(input logic signed [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] mul_sext(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_d(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  state_t                    r_state;
  logic [1:0]                r_mode;
  logic [BEATS_W-1:0]        r_beats;
  logic [SHIFT_W-1:0]        r_shift;
  logic                      r_relu;
  logic [BEATS_W-1:0]        r_cnt;
  logic                      r_last;
  logic signed [ACC_W-1:0]   r_acc  [N_CH];
  logic signed [DATA_W-1:0]  r_bias [N_CH];
  logic                      r_cfg_ready;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;
  logic                      r_err_mode;
  logic [N_CH*DATA_W-1:0]    r_ofm;

  logic signed [DATA_W-1:0]  w_ifm     [LANES];
  logic signed [DATA_W-1:0]  w_wgt     [N_CH][LANES];
  logic signed [DATA_W-1:0]  w_bias_in [N_CH];
  logic signed [ACC_W-1:0]   w_acc_nxt [N_CH];
  logic signed [ACC_W-1:0]   w_biased  [N_CH];
  logic signed [ACC_W-1:0]   w_scaled  [N_CH];
  logic signed [ACC_W-1:0]   w_rect    [N_CH];
  logic signed [DATA_W-1:0]  w_res     [N_CH];
  logic [BEATS_W-1:0]        w_beats_eff;
  logic                      w_beat_hs;
  logic                      w_last_beat;

  assign w_beat_hs   = bus.in_valid && r_in_ready;
  assign w_beats_eff = (r_beats == BEAT_ZERO) ? BEAT_ONE : r_beats;
  assign w_last_beat = ({1'b0, r_cnt} + {1'b0, BEAT_ONE}) >= {1'b0, w_beats_eff};

  // Unpack the flat beat buses into signed lanes.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_ifm[i] = bus.ifm_data[i*DATA_W +: DATA_W];
    end
    for (int c = 0; c < N_CH; c++) begin
      w_bias_in[c] = bus.bias_data[c*DATA_W +: DATA_W];
      for (int i = 0; i < LANES; i++) begin
        w_wgt[c][i] = bus.wgt_data[(c*LANES+i)*DATA_W +: DATA_W];
      end
    end
  end

  // Per-channel accumulator update for the beat currently offered.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_acc_nxt[c] = r_acc[c];
      case (r_mode)
        M_CONV: begin
          for (int i = 0; i < LANES; i++) begin
            w_acc_nxt[c] = w_acc_nxt[c] + mul_sext(w_ifm[i], w_wgt[c][i]);
          end
        end
        M_FULLY: w_acc_nxt[c] = r_acc[c] + mul_sext(w_ifm[0], w_wgt[c][0]);
        // First pool beat loads directly so an all-negative window is not clamped to 0.
        M_POOL: begin
          if ((r_cnt == BEAT_ZERO) || (sext_d(w_ifm[c]) > r_acc[c])) begin
            w_acc_nxt[c] = sext_d(w_ifm[c]);
          end else begin
            w_acc_nxt[c] = r_acc[c];
          end
        end
        default: w_acc_nxt[c] = r_acc[c];
      endcase
    end
  end

  // Requantise: bias, floor shift, ReLU, saturate (pool skips bias and shift).
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_biased[c] = r_acc[c] + sext_d(r_bias[c]);
      if (r_mode == M_POOL) begin
        w_scaled[c] = r_acc[c];
      end else begin
        w_scaled[c] = w_biased[c] >>> r_shift;
      end
      if (r_relu && w_scaled[c][ACC_W-1]) begin
        w_rect[c] = ACC_ZERO;
      end else begin
        w_rect[c] = w_scaled[c];
      end
      w_res[c] = sat_d(w_rect[c]);
    end
  end

  // Control FSM with all handshake/status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_beats     <= BEAT_ZERO;
      r_shift     <= {SHIFT_W{1'b0}};
      r_relu      <= 1'b0;
      r_cnt       <= BEAT_ZERO;
      r_last      <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err_mode  <= 1'b0;
      r_ofm       <= {(N_CH*DATA_W){1'b0}};
      for (int c = 0; c < N_CH; c++) begin
        r_acc[c]  <= ACC_ZERO;
        r_bias[c] <= {DATA_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cfg_ready <= 1'b1;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          if (bus.cfg_valid && r_cfg_ready) begin
            r_mode  <= bus.cfg_mode;
            r_beats <= bus.cfg_beats;
            r_shift <= bus.cfg_shift;
            r_relu  <= bus.cfg_relu;
            r_cnt   <= BEAT_ZERO;
            r_last  <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
              r_acc[c] <= ACC_ZERO;
            end
            if (bus.cfg_mode == M_ILL) begin
              r_err_mode <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_cfg_ready <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        // One settle cycle after the last beat keeps the MAC tree off the requantise path.
        S_RUN: begin
          if (r_last) begin
            r_state <= S_FINAL;
          end else if (w_beat_hs) begin
            r_cnt <= r_cnt + BEAT_ONE;
            for (int c = 0; c < N_CH; c++) begin
              r_acc[c] <= w_acc_nxt[c];
              if (r_cnt == BEAT_ZERO) begin
                r_bias[c] <= w_bias_in[c];
              end
            end
            if (w_last_beat) begin
              r_in_ready <= 1'b0;
              r_last     <= 1'b1;
            end
          end
        end
        S_FINAL: begin
          for (int c = 0; c < N_CH; c++) begin
            r_ofm[c*DATA_W +: DATA_W] <= w_res[c];
          end
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ofm_data  = r_ofm;
  assign bus.busy      = r_busy;
  assign bus.err_mode  = r_err_mode;

endmodule

// File: tb/tb_mito_acc_core.sv
// Directed bench for mito_acc_core: hand-computed tiles for every mode plus control corner cases.
module tb_mito_acc_core;
  localparam int DW = 8;
  localparam int LN = 9;
  localparam int NC = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mito_acc_core_if #(.DATA_W(DW), .LANES(LN), .N_CH(NC), .BEATS_W(8), .SHIFT_W(4)) bus ();

  mito_acc_core #(.DATA_W(DW), .ACC_W(24), .LANES(LN), .N_CH(NC), .BEATS_W(8), .SHIFT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] rep(input logic [7:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [LN*DW-1:0] ifm_all(input logic [7:0] v);
    logic [LN*DW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NC*LN*DW-1:0] wgt_all(input logic [7:0] v);
    logic [NC*LN*DW-1:0] r;
    for (int i = 0; i < NC*LN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic cfg(input logic [1:0] mode, input logic [7:0] beats,
                     input logic [3:0] shift, input logic relu);
    bus.cfg_mode  = mode;
    bus.cfg_beats = beats;
    bus.cfg_shift = shift;
    bus.cfg_relu  = relu;
    bus.cfg_valid = 1'b1;
    for (int k = 0; k < 20 && !bus.cfg_ready; k++) @(negedge clk);
    chk("cfg_ready_wait", bus.cfg_ready, 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [LN*DW-1:0] ifm, input logic [NC*LN*DW-1:0] wgt,
                      input logic [NC*DW-1:0] bias);
    bus.ifm_data  = ifm;
    bus.wgt_data  = wgt;
    bus.bias_data = bias;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
    chk("in_ready_wait", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [NC*DW-1:0] exp);
    for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk(tag, bus.ofm_data, exp);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, bus.out_valid, 0);
    chk({tag, "_idle"}, {bus.busy, bus.cfg_ready}, 2'b01);
  endtask

  initial begin
    logic [LN*DW-1:0]    v_ifm;
    logic [NC*LN*DW-1:0] v_wgt;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_mode = 2'b00; bus.cfg_beats = 8'd0;
    bus.cfg_shift = 4'd0; bus.cfg_relu = 1'b0; bus.in_valid = 1'b0;
    bus.ifm_data = '0; bus.wgt_data = '0; bus.bias_data = '0; bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.out_valid, bus.in_ready, bus.busy, bus.err_mode, bus.cfg_ready}, 5'b0);
    chk("rst_ofm", bus.ofm_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cfg_ready_after_rst", bus.cfg_ready, 1);

    // CONVOL 2 beats: 9*1*2*2 = 36, (36+5)>>>1 = 20, with latency check
    cfg(2'b01, 8'd2, 4'd1, 1'b0);
    chk("run_busy", {bus.busy, bus.in_ready, bus.cfg_ready}, 3'b110);
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd5));
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd9));
    chk("lat_0", bus.out_valid, 0);
    chk("fin_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("lat_1", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_2", bus.out_valid, 1);
    expect_out("conv_basic", rep(8'd20));

    // CONVOL 4 beats of -18: -72, then with ReLU 0
    cfg(2'b01, 8'd4, 4'd0, 1'b0);
    repeat (4) beat(ifm_all(8'd1), wgt_all(8'hFE), rep(8'd0));
    expect_out("conv_neg", rep(8'hB8));
    cfg(2'b01, 8'd4, 4'd0, 1'b1);
    repeat (4) beat(ifm_all(8'd1), wgt_all(8'hFE), rep(8'd0));
    expect_out("conv_relu", rep(8'h00));

    // Saturation: 9*127*127 = 145161 -> 127, 9*127*-128 -> -128
    cfg(2'b01, 8'd1, 4'd0, 1'b0);
    beat(ifm_all(8'd127), wgt_all(8'd127), rep(8'd0));
    expect_out("sat_pos", rep(8'h7F));
    cfg(2'b01, 8'd1, 4'd0, 1'b0);
    beat(ifm_all(8'd127), wgt_all(8'h80), rep(8'd0));
    expect_out("sat_neg", rep(8'h80));

    // FULLY: lane0 only, ch c weight c+1, ifm 1,2,3 -> 6,12,18,24
    cfg(2'b10, 8'd3, 4'd0, 1'b0);
    v_wgt = wgt_all(8'd7);
    for (int c = 0; c < NC; c++) v_wgt[(c*LN)*DW +: DW] = 8'(c + 1);
    for (int b = 1; b <= 3; b++) begin
      v_ifm = ifm_all(8'd50);
      v_ifm[7:0] = 8'(b);
      beat(v_ifm, v_wgt, rep(8'd0));
    end
    expect_out("fully", {8'd24, 8'd18, 8'd12, 8'd6});

    // POOL: lane c = {-5,7,3}+c -> 7+c; bias/shift must be ignored
    cfg(2'b11, 8'd3, 4'd2, 1'b0);
    for (int b = 0; b < 3; b++) begin
      v_ifm = ifm_all(8'd0);
      for (int c = 0; c < NC; c++) v_ifm[c*DW +: DW] = 8'((b == 0 ? -5 : (b == 1 ? 7 : 3)) + c);
      beat(v_ifm, wgt_all(8'h55), rep(8'd5));
    end
    expect_out("pool_pos", {8'd10, 8'd9, 8'd8, 8'd7});
    for (int r = 0; r < 2; r++) begin
      cfg(2'b11, 8'd3, 4'd0, r[0]);
      beat(ifm_all(8'hF7), wgt_all(8'd0), rep(8'd0));
      beat(ifm_all(8'hFC), wgt_all(8'd0), rep(8'd0));
      beat(ifm_all(8'hFA), wgt_all(8'd0), rep(8'd0));
      expect_out(r == 0 ? "pool_neg" : "pool_neg_relu", r == 0 ? rep(8'hFC) : rep(8'h00));
    end

    // Illegal mode: sticky error, stays idle, no output
    chk("err_before", bus.err_mode, 0);
    cfg(2'b00, 8'd1, 4'd0, 1'b0);
    repeat (3) begin
      chk("ill_state", {bus.err_mode, bus.cfg_ready, bus.busy, bus.out_valid, bus.in_ready}, 5'b11000);
      @(negedge clk);
    end

    // Input gap, then output stall while extra beats and a cfg are offered
    cfg(2'b01, 8'd2, 4'd1, 1'b0);
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd5));
    repeat (3) begin
      chk("gap_run", {bus.in_ready, bus.out_valid}, 2'b10);
      @(negedge clk);
    end
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd0));
    for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ifm_data = ifm_all(8'd100);
    bus.cfg_valid = 1'b1;
    repeat (5) begin
      chk("stall_ofm", bus.ofm_data, rep(8'd20));
      chk("stall_ctl", {bus.out_valid, bus.in_ready, bus.cfg_ready}, 3'b100);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.cfg_valid = 1'b0;
    expect_out("stall_out", rep(8'd20));

    // Reset mid-RUN abandons the tile; next tile starts clean
    cfg(2'b01, 8'd3, 4'd0, 1'b0);
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {bus.out_valid, bus.in_ready, bus.busy, bus.err_mode, bus.cfg_ready}, 5'b0);
    chk("midrst_ofm", bus.ofm_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", {bus.cfg_ready, bus.busy}, 2'b10);
    cfg(2'b01, 8'd1, 4'd0, 1'b0);
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd0));
    expect_out("after_rst", rep(8'd18));

    // cfg_beats = 0 acts as a single beat
    cfg(2'b01, 8'd0, 4'd0, 1'b0);
    beat(ifm_all(8'd1), wgt_all(8'd2), rep(8'd0));
    chk("beats0_stop", bus.in_ready, 0);
    expect_out("beats0", rep(8'd18));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
